// File: rtl/line_memory.sv
// Line-wide main memory: one 64-bit line per access, fixed LATENCY cycles in BUSY,
// completion flagged by a one-cycle registered rdy pulse.
module line_memory #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic [63:0]       rd_data,
  output logic              rdy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                op_write_reg, op_write_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [63:0]         wdata_reg, wdata_next;
  logic                rdy_reg;
  logic                commit;
  logic                write_en;
  logic                read_en;

  // Access is performed on the final BUSY edge; state is IDLE while reset is held,
  // so an aborted write can never reach the array.
  assign commit   = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign write_en = commit && op_write_reg;
  assign read_en  = commit && !op_write_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      op_write_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= 64'h0;
      rdy_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      op_write_reg <= op_write_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rdy_reg      <= commit;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    op_write_next = op_write_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    case (state_reg)
      IDLE: begin
        // Simultaneous re/we resolves to a write; the controller re-issues the read.
        if (re || we) begin
          op_write_next = we;
          addr_next     = addr;
          wdata_next    = wdata;
          cnt_next      = 4'(LATENCY - 1);
          state_next    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One 16-bit RAM lane per word; each lane holds its own slice of the read register.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [15:0] mem [0:(1<<ADDR_W)-1];
      logic [15:0] rd_word_reg;

      always_ff @(posedge clk) begin
        if (write_en) begin
          mem[addr_reg] <= wdata_reg[gi*16 +: 16];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_word_reg <= 16'h0;
        end else if (read_en) begin
          rd_word_reg <= mem[addr_reg];
        end
      end

      assign rd_data[gi*16 +: 16] = rd_word_reg;
    end
  endgenerate

  assign rdy = rdy_reg;

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: a scoreboard queue holds the expected result of every
// accepted access and is drained on each rdy pulse.
module tb_line_memory;
  localparam int L = 4;

  logic        clk;
  logic        rst_n;
  logic        re;
  logic        we;
  logic [13:0] addr;
  logic [63:0] wdata;
  logic [63:0] rd_data;
  logic        rdy;

  line_memory #(.LATENCY(L), .ADDR_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .addr(addr),
    .wdata(wdata), .rd_data(rd_data), .rdy(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [63:0] data;
  } sb_t;

  sb_t         sb[$];
  logic [63:0] mem_model [int];
  logic [63:0] rd_model;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        prev_rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit r, input bit w, input logic [13:0] a, input logic [63:0] d);
    sb_t e;
    if (w) begin
      mem_model[int'(a)] = d;
      e.is_read = 1'b0;
      e.data    = 64'h0;
    end else begin
      e.is_read = 1'b1;
      e.data    = mem_model[int'(a)];
    end
    if (r || w) sb.push_back(e);
  endtask

  // Scoreboard drain: one pop per rdy pulse, sampled on the falling edge.
  initial prev_rdy = 1'b0;
  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      check("rdy_not_consecutive", {63'h0, prev_rdy}, 64'h0);
      check("rdy_has_request", {63'h0, sb.size() != 0}, 64'h1);
      if (sb.size() != 0) begin
        sb_t e;
        e = sb.pop_front();
        if (e.is_read) begin
          check("read_data", rd_data, e.data);
          rd_model = e.data;
          $display("read  done rd_data=%h", rd_data);
        end else begin
          check("write_keeps_rd_data", rd_data, rd_model);
          $display("write done rd_data=%h", rd_data);
        end
      end
    end
    prev_rdy = rdy;
  end

  // One access: request held for exactly the accept edge, optionally with inputs
  // wiggled during BUSY to prove they are ignored.
  task automatic access(input bit r, input bit w, input logic [13:0] a, input logic [63:0] d,
                        input bit wiggle, input logic [13:0] a2, input logic [63:0] d2);
    @(negedge clk);
    re = r; we = w; addr = a; wdata = d;
    push(r, w, a, d);
    @(posedge clk); #1;
    re = 1'b0; we = wiggle ? w : 1'b0;
    if (wiggle) begin
      addr = a2; wdata = d2;
    end
    for (int k = 1; k <= L; k++) begin
      @(posedge clk); #1;
      check("rdy_latency", {63'h0, rdy}, {63'h0, k == L});
      if (k == L) we = 1'b0;
    end
    @(posedge clk); #1;
    check("rdy_one_cycle", {63'h0, rdy}, 64'h0);
  endtask

  initial begin
    int first;
    int second;
    re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    rd_model = 64'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", {63'h0, rdy}, 64'h0);
    check("reset_rd_data", rd_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_rdy", {63'h0, rdy}, 64'h0);

    // Write then read back line 5.
    access(1'b0, 1'b1, 14'h0005, 64'h4444_3333_2222_1111, 1'b0, '0, '0);
    access(1'b1, 1'b0, 14'h0005, 64'h0, 1'b0, '0, '0);
    check("rd_data_holds", rd_data, 64'h4444_3333_2222_1111);

    // Asynchronous reset pulse between edges clears rd_data at once.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_rd_data", rd_data, 64'h0);
    check("async_rst_rdy", {63'h0, rdy}, 64'h0);
    #1 rst_n = 1'b1;
    rd_model = 64'h0;

    // re and we together behave as a write.
    access(1'b1, 1'b1, 14'h3FFF, 64'hDEAD_BEEF_0000_FFFF, 1'b0, '0, '0);
    access(1'b1, 1'b0, 14'h3FFF, 64'h0, 1'b0, '0, '0);

    // Inputs changed during BUSY must not redirect the write.
    access(1'b0, 1'b1, 14'h0020, 64'h2020_2020_2020_2020, 1'b0, '0, '0);
    access(1'b0, 1'b1, 14'h0010, 64'h1010_AAAA_5555_0101, 1'b1, 14'h0020, 64'hBAD0_BAD0_BAD0_BAD0);
    access(1'b1, 1'b0, 14'h0010, 64'h0, 1'b0, '0, '0);
    access(1'b1, 1'b0, 14'h0020, 64'h0, 1'b0, '0, '0);

    // we held high: back-to-back writes to lines 1 and 2.
    @(negedge clk);
    we = 1'b1; addr = 14'h0001; wdata = 64'h0101_0101_0101_0101;
    push(1'b0, 1'b1, 14'h0001, 64'h0101_0101_0101_0101);
    push(1'b0, 1'b1, 14'h0002, 64'h0202_0202_0202_0202);
    @(posedge clk); #1;
    addr = 14'h0002; wdata = 64'h0202_0202_0202_0202;
    first = -1; second = -1;
    for (int k = 1; k <= 3 * L + 6 && second < 0; k++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) begin
        if (first < 0) first = k;
        else second = k;
      end
    end
    we = 1'b0;
    check("held_first_rdy", 64'(first), 64'(L));
    check("held_accept_gap", 64'(second - first), 64'(L + 2));
    repeat (L + 3) @(posedge clk);
    access(1'b1, 1'b0, 14'h0001, 64'h0, 1'b0, '0, '0);
    access(1'b1, 1'b0, 14'h0002, 64'h0, 1'b0, '0, '0);

    // Write aborted by reset in BUSY cycle 2 leaves line 7 untouched and no rdy.
    access(1'b0, 1'b1, 14'h0007, 64'h1, 1'b0, '0, '0);
    @(negedge clk);
    we = 1'b1; addr = 14'h0007; wdata = 64'h7777_7777_7777_7777;
    @(posedge clk); #1;
    we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_rdy", {63'h0, rdy}, 64'h0);
    check("abort_rd_data", rd_data, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_model = 64'h0;
    repeat (L + 2) @(posedge clk);
    #1;
    check("abort_no_rdy", {63'h0, rdy}, 64'h0);
    access(1'b1, 1'b0, 14'h0007, 64'h0, 1'b0, '0, '0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/line_memory.md
# line_memory

Multi-cycle, line-wide main memory that sits directly downstream of the cache controller in the memory hierarchy. It serves both I-cache refills and D-cache write-backs. Every access moves one 64-bit line (four 16-bit words) at a 14-bit line address and takes a fixed, parameterised number of cycles. Completion is signalled by a single-cycle `rdy` pulse, which the controller uses to advance its refill and write-back sequence.

## Interface
- `LATENCY`, default 4: cycles spent in BUSY per access; legal range 1..15.
- `ADDR_W`, default 14: line-address width; array depth is 2^ADDR_W lines.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `re` input, 1 bit: read-line request, level.
- `we` input, 1 bit: write-line request, level.
- `addr` input, ADDR_W bits: line address.
- `wdata` input, 64 bits: write line; word 0 in [15:0], word 3 in [63:48].
- `rd_data` output, 64 bits: last line read, registered.
- `rdy` output, 1 bit: access-complete pulse, registered.

## Operation
- States: IDLE, BUSY, DONE. A 4-bit down-counter `cnt` runs in BUSY.
- IDLE:
  - `re | we` sampled at an edge: latch `addr`, `wdata` and the operation, set `cnt` = LATENCY-1, go to BUSY.
  - `re & we` both high: treated as a write. The write-back is done first; the controller re-requests the read afterwards.
- BUSY:
  - Request inputs are ignored. Changes on `re`, `we`, `addr` or `wdata` do not affect the access already latched.
  - Each edge with `cnt` != 0 decrements `cnt`.
  - Edge with `cnt` == 0: perform the access and go to DONE.
    - Write: array[latched addr] <= latched wdata.
    - Read: `rd_data` <= array[latched addr].
- DONE: `rdy` = 1 for exactly this one cycle. Inputs are ignored. Go to IDLE on the next edge.
- IDLE after DONE: a request still held high in the first IDLE cycle starts a new access. This permits back-to-back accesses (write-back, then refill).
- `rd_data` holds its value until the next read completes. A write never changes `rd_data`.
- Read-after-write to the same address returns the new data. The write is committed to the array no later than the edge that enters DONE.
- Array contents are not cleared by reset. Reading a never-written line returns X in simulation; no other defined value.

## Timing
- Reset values: state IDLE, `rdy` = 0, `rd_data` = 64'h0, `cnt` = 0.
- Reset asserted mid-access:
  - Immediate return to IDLE; `rdy` stays 0.
  - A pending write is discarded and the array line is unchanged.
  - A pending read leaves `rd_data` = 0.
- Latency: request sampled at edge E0; DONE entered at edge E0+LATENCY; `rdy` high between E0+LATENCY and E0+LATENCY+1.
  - Read: `rd_data` valid from E0+LATENCY onward.
  - Minimum spacing between request-accept edges: LATENCY+2.
- `rdy` is never high in two consecutive cycles.
- `rdy` is never high without a preceding accepted request.
- No combinational path from any input to any output.

## Test plan
- Reset, then pulse `rst_n` low between edges (async) -> `rdy` = 0 and `rd_data` = 0 immediately; IDLE held with `re` = `we` = 0.
- LATENCY=4:
  - Write addr 14'h0005, data 64'h4444_3333_2222_1111, then read addr 14'h0005 -> each `rdy` pulse is 1 cycle, 4 cycles after accept; `rd_data` = 64'h4444_3333_2222_1111.
  - `re` and `we` both high, addr 14'h3FFF, data 64'hDEAD_BEEF_0000_FFFF -> write performed; a following read of 14'h3FFF returns 64'hDEAD_BEEF_0000_FFFF.
- Change `addr` from 14'h0010 to 14'h0020 and `wdata` mid-BUSY during a write -> only line 14'h0010 is updated; line 14'h0020 is unchanged.
- `we` held high continuously, 14'h0001 then 14'h0002 -> accepts spaced exactly LATENCY+2 cycles apart; each write commits its own latched data.
- Write to 14'h0007 with reset asserted at BUSY cycle 2 (line previously written with 64'h1) -> after reset, a read of 14'h0007 returns 64'h1; no `rdy` pulse for the aborted access.
